pipe_scheduler: RTL
===================

# pipe_scheduler

Scroll, respawn and collision sequencer for the pipe-gap datapath. It sits between the controller's scene/bird state and the view. It owns the `gaps` word the view draws, advancing every pipe leftward on a divided tick, recycling off-screen pipes with pseudo-random gap bounds, counting passed pipes, and flagging bird/pipe or ground collisions so the controller can switch to the game-over scene.

## Interface
- `SCROLL_DIV`, default 10: clock cycles per scroll tick.
- `GAP_H`, default 10: row distance `max_bnd - min_bnd` of a respawned gap.
- `PIPE_SPACING`, default 20: column spacing between pipes. Respawn column is `3*PIPE_SPACING-1`.
- `clk`  in  1: clock; all state on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `n_row`  in  8: terminal rows; required to be >= 30.
- `n_col`  in  8: terminal columns.
- `scene`  in  2: 0 splash, 1 playing, 2 game over.
- `altitude`  in  8: bird altitude, rows above the bottom.
- `gaps`  out  72: three pipes; slot i is `gaps[24*i+:24]` = {position, max_bnd, min_bnd}.
- `score`  out  8: pipes passed, saturating at 255.
- `score_pulse`  out  1: high for one cycle when `score` increments.
- `collide`  out  1: high while in HALT.

## Operation
- Reset and IDLE layout: `gaps` = {8'd20,8'd30,8'd20, 8'd40,8'd25,8'd15, 8'd60,8'd35,8'd25}, so slot 2 is at position 20.
- Reset values of the other outputs: `score`=0, `score_pulse`=0, `collide`=0.
- Internal reset values: state IDLE, divider 0, LFSR 8'hA5.
- States:
  - IDLE → RUN when `scene`==1.
  - RUN → HALT on collision.
  - RUN → IDLE when `scene`==0.
  - HALT → IDLE when `scene`==0.
  - Every transition into IDLE reloads the reset layout and clears `score` and `collide`.
- Divider: counts 0..SCROLL_DIV-1 only in RUN and is held at 0 elsewhere. A tick occurs when divider==SCROLL_DIV-1.
- On a tick, per slot:
  - position==0: respawn. Position becomes `3*PIPE_SPACING-1`, min_bnd = 2 + lfsr[3:0], max_bnd = min_bnd + GAP_H.
  - Otherwise: position decrements by 1 and the bounds are unchanged.
  - Any slot with position==1 makes `score` increment by 1 (saturating) and raises `score_pulse`. At most one slot can be at 1.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle in every state. A respawn uses the pre-edge value.
- Collision is combinational on current registers, evaluated only in RUN. Bird row r = n_row - altitude (8-bit). Collision is true if either:
  - altitude==0 or altitude>=n_row (ground or ceiling), or
  - any slot has position<=8 and (r<=min_bnd or r>=max_bnd). Caps count as pipe; the gap is strictly between the bounds.
- HALT: `gaps` and `score` are frozen and `collide`=1.

## Timing
- All outputs are registered with no combinational path from input to output. Collision is registered: `collide` rises on the edge where RUN sees the condition, and that same edge enters HALT.
- A tick and a collision in the same cycle: collision wins. No scroll, no score, no respawn on that edge.
- `scene`==0 and a collision in the same RUN cycle: go to IDLE.
- First tick is SCROLL_DIV cycles after entering RUN.
- Leaving RUN and re-entering restarts the divider at 0.
- `score_pulse` is a single cycle aligned with the `score` update. At saturation, `score` stays 255 and `score_pulse` still pulses.
- `rst` asserted at any point immediately forces all reset values regardless of state. Release is synchronous to `clk` by the integrator.

## Test plan
- Reset: assert `rst` → `gaps` equals the literal layout, `score`=0, `collide`=0. `scene`=1 held with no clock edge → outputs unchanged.
- Scroll: n_row=40, altitude=15, `scene`=1 → after 10 cycles slot-2 position is 19. After 120 cycles it is 8 with `collide`=0 (r=25 lies in 20..30).
- Score and respawn: continue the previous run with altitude tracking the gaps → the tick taking slot 2 from 1 to 0 gives `score`=1 with a 1-cycle `score_pulse`. The next tick sets slot 2 position to 59, min_bnd = 2 + lfsr[3:0], max_bnd = min_bnd + 10.
- Pipe collision: n_row=40, altitude=5 (r=35), `scene`=1 → after 12 ticks slot 2 is at position 8. Check the collision edge, the HALT entry and that `gaps` stays frozen.
- Ground: `scene`=1, altitude=0 → `collide`=1 on the first RUN edge. No scroll occurs even if that cycle is a tick.
- Restart and async reset: from HALT, drive `scene`=0 → IDLE with the literal layout, `score`=0, `collide`=0. Assert `rst` mid-RUN between edges → outputs reset immediately.

Source files
------------

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: scroll, respawn and collision sequencer for the pipe-gap
// datapath. Owns the gaps word drawn by the view, scrolls pipes leftward on
// a divided tick, recycles off-screen pipes with LFSR-derived gap bounds,
// counts passed pipes and flags bird/pipe or ground/ceiling collisions.
//
// state | meaning
// IDLE  | reset layout shown, divider held, waiting for scene==playing
// RUN   | divider counting, pipes scroll on tick, collision checked
// HALT  | collision seen, gaps/score frozen, collide held high
module pipe_scheduler #(
  parameter int SCROLL_DIV   = 10,
  parameter int GAP_H        = 10,
  parameter int PIPE_SPACING = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  n_row,
  input  logic [7:0]  n_col,
  input  logic [1:0]  scene,
  input  logic [7:0]  altitude,
  output logic [71:0] gaps,
  output logic [7:0]  score,
  output logic        score_pulse,
  output logic        collide
);

  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [7:0] RESPAWN_POS = 8'(3 * PIPE_SPACING - 1);
  localparam logic [7:0] GAP_H_W = 8'(GAP_H);
  localparam logic [71:0] LAYOUT = {8'd20, 8'd30, 8'd20,
                                    8'd40, 8'd25, 8'd15,
                                    8'd60, 8'd35, 8'd25};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [71:0]      gaps_q, gaps_d;
  logic [7:0]       score_q, score_d;
  logic             score_pulse_q, score_pulse_d;
  logic             collide_q, collide_d;

  logic [7:0]       bird_row;
  logic             collision;
  logic             tick;
  logic             slot_at_one;
  logic [7:0]       new_min;

  // n_col is part of the scene interface but pipes never depend on width
  logic unused_n_col;
  assign unused_n_col = ^n_col;

  // Collision against ground, ceiling, and any pipe within the bird columns
  always_comb begin
    bird_row  = n_row - altitude;
    collision = (altitude == 8'd0) || (altitude >= n_row);
    for (int i = 0; i < 3; i++) begin
      if ((gaps_q[24*i+16 +: 8] <= 8'd8) &&
          ((bird_row <= gaps_q[24*i +: 8]) || (bird_row >= gaps_q[24*i+8 +: 8]))) begin
        collision = 1'b1;
      end
    end
  end

  // Next-state logic: FSM, divider, scroll/respawn, score and collide flag
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    gaps_d        = gaps_q;
    score_d       = score_q;
    score_pulse_d = 1'b0;
    collide_d     = collide_q;
    lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    tick          = (div_q == DIV_LAST);
    slot_at_one   = 1'b0;
    new_min       = 8'd2 + {4'd0, lfsr_q[3:0]};

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (scene == 2'd1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (scene == 2'd0) begin
          state_d   = IDLE;
          div_d     = '0;
          gaps_d    = LAYOUT;
          score_d   = 8'd0;
          collide_d = 1'b0;
        end else if (collision) begin
          // collision beats a coincident tick: nothing scrolls on this edge
          state_d   = HALT;
          div_d     = '0;
          collide_d = 1'b1;
        end else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick) begin
            for (int i = 0; i < 3; i++) begin
              if (gaps_q[24*i+16 +: 8] == 8'd0) begin
                gaps_d[24*i+16 +: 8] = RESPAWN_POS;
                gaps_d[24*i+8 +: 8]  = new_min + GAP_H_W;
                gaps_d[24*i +: 8]    = new_min;
              end else begin
                gaps_d[24*i+16 +: 8] = gaps_q[24*i+16 +: 8] - 8'd1;
              end
              if (gaps_q[24*i+16 +: 8] == 8'd1) begin
                slot_at_one = 1'b1;
              end
            end
            if (slot_at_one) begin
              score_d       = (score_q == 8'd255) ? 8'd255 : score_q + 8'd1;
              score_pulse_d = 1'b1;
            end
          end
        end
      end
      HALT: begin
        div_d = '0;
        if (scene == 2'd0) begin
          state_d   = IDLE;
          gaps_d    = LAYOUT;
          score_d   = 8'd0;
          collide_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        div_d     = '0;
        gaps_d    = LAYOUT;
        score_d   = 8'd0;
        collide_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      lfsr_q        <= 8'hA5;
      gaps_q        <= LAYOUT;
      score_q       <= 8'd0;
      score_pulse_q <= 1'b0;
      collide_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      lfsr_q        <= lfsr_d;
      gaps_q        <= gaps_d;
      score_q       <= score_d;
      score_pulse_q <= score_pulse_d;
      collide_q     <= collide_d;
    end
  end

  assign gaps        = gaps_q;
  assign score       = score_q;
  assign score_pulse = score_pulse_q;
  assign collide     = collide_q;

endmodule
